// File: rtl/pipe_stage_latch_pkg.sv
// Shared definitions for the inter-stage pipeline latch: FSM state encoding and bubble default.
// Encoding 2'd3 is unused; the FSM treats it as a path back to EMPTY.
package pipe_stage_latch_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } ps_state_t;

    localparam logic [31:0] NOP_INSTR_DFLT = 32'h0;

endpackage

// File: rtl/pipe_stage_latch_entry_reg.sv
// One {valid, IR, PC_next} slot of the pipeline latch; loads on en, forces a bubble on bubble.
// Latency: 1 cycle from d_* to q_*.
// Backpressure: none of its own; the parent decides when to load or bubble.
module pipe_stage_latch_entry_reg #(
    parameter int              IR_W      = 32,
    parameter int              PC_W      = 32,
    parameter logic [IR_W-1:0] NOP_INSTR = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            bubble,
    input  logic            d_valid,
    input  logic [IR_W-1:0] d_ir,
    input  logic [PC_W-1:0] d_pc,
    output logic            q_valid,
    output logic [IR_W-1:0] q_ir,
    output logic [PC_W-1:0] q_pc
);

    // Bubble wins over a load so a flush can never be overridden by a same-cycle transfer.
    always_ff @(posedge clock) begin
        if (!reset || bubble) begin
            q_valid <= 1'b0;
            q_ir    <= NOP_INSTR;
            q_pc    <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_ir    <= d_ir;
            q_pc    <= d_pc;
        end
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// Flow-controlled inter-stage latch with a head register and a skid register, plus stall counter.
// Latency: 1 cycle in->out; throughput 1/cycle while out_ready stays high.
// Backpressure: in_ready is registered (low only in TWO), so no comb path from out_ready.
module pipe_stage_latch
    import pipe_stage_latch_pkg::*;
#(
    parameter int              IR_W      = 32,
    parameter int              PC_W      = 32,
    parameter logic [IR_W-1:0] NOP_INSTR = IR_W'(NOP_INSTR_DFLT),
    parameter int              CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IR_W-1:0]  in_IR,
    input  logic [PC_W-1:0]  in_PC_next,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IR_W-1:0]  out_IR,
    output logic [PC_W-1:0]  out_PC_next,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ps_state_t state;
    ps_state_t nxt;

    logic accept;
    logic consume;

    logic head_en;
    logic head_bub;
    logic head_from_skid;
    logic skid_en;
    logic skid_bub;

    logic            head_valid;
    logic [IR_W-1:0] head_ir;
    logic [PC_W-1:0] head_pc;
    logic            skid_valid;
    logic [IR_W-1:0] skid_ir;
    logic [PC_W-1:0] skid_pc;

    logic            head_d_valid;
    logic [IR_W-1:0] head_d_ir;
    logic [PC_W-1:0] head_d_pc;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= PS_EMPTY;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        if (flush) begin
            nxt = PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: if (accept) nxt = PS_ONE;
                PS_ONE: begin
                    if (accept && !consume) begin
                        nxt = PS_TWO;
                    end else if (!accept && consume) begin
                        nxt = PS_EMPTY;
                    end
                end
                PS_TWO:   if (consume) nxt = PS_ONE;
                default:  nxt = PS_EMPTY;
            endcase
        end
    end

    // Register controls; the head is bubbled whenever it empties so out_IR/out_PC_next
    // come straight from flops and already show NOP_INSTR/0 while out_valid is low.
    always_comb begin
        head_en        = 1'b0;
        head_bub       = 1'b0;
        head_from_skid = 1'b0;
        skid_en        = 1'b0;
        skid_bub       = 1'b0;
        if (flush) begin
            head_bub = 1'b1;
            skid_bub = 1'b1;
        end else begin
            case (state)
                PS_EMPTY: head_en = accept;
                PS_ONE: begin
                    head_en  = accept & consume;
                    skid_en  = accept & ~consume;
                    head_bub = ~accept & consume;
                end
                PS_TWO: begin
                    if (consume) begin
                        head_en        = 1'b1;
                        head_from_skid = 1'b1;
                        skid_bub       = 1'b1;
                    end
                end
                default: begin
                    head_bub = 1'b1;
                    skid_bub = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= (nxt != PS_TWO);
        end
    end

    assign head_d_valid = head_from_skid ? skid_valid : 1'b1;
    assign head_d_ir    = head_from_skid ? skid_ir    : in_IR;
    assign head_d_pc    = head_from_skid ? skid_pc    : in_PC_next;

    pipe_stage_latch_entry_reg #(
        .IR_W      (IR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_head (
        .clock   (clock),
        .reset   (reset),
        .en      (head_en),
        .bubble  (head_bub),
        .d_valid (head_d_valid),
        .d_ir    (head_d_ir),
        .d_pc    (head_d_pc),
        .q_valid (head_valid),
        .q_ir    (head_ir),
        .q_pc    (head_pc)
    );

    pipe_stage_latch_entry_reg #(
        .IR_W      (IR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .en      (skid_en),
        .bubble  (skid_bub),
        .d_valid (1'b1),
        .d_ir    (in_IR),
        .d_pc    (in_PC_next),
        .q_valid (skid_valid),
        .q_ir    (skid_ir),
        .q_pc    (skid_pc)
    );

    assign out_valid   = head_valid;
    assign out_IR      = head_ir;
    assign out_PC_next = head_pc;

    // Flush does not touch the counter: stalls seen before a flush still count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Randomised and directed bench for pipe_stage_latch against a queue-based reference model.
module tb_pipe_stage_latch;

    localparam int              IR_W      = 32;
    localparam int              PC_W      = 32;
    localparam int              CNT_W     = 16;
    localparam logic [IR_W-1:0] NOP       = 32'h0000_0013;
    localparam int unsigned     CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pc;
    } ent_t;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             flush      = 1'b0;
    logic             in_valid   = 1'b0;
    logic             in_ready;
    logic [IR_W-1:0]  in_IR      = '0;
    logic [PC_W-1:0]  in_PC_next = '0;
    logic             out_valid;
    logic             out_ready  = 1'b0;
    logic [IR_W-1:0]  out_IR;
    logic [PC_W-1:0]  out_PC_next;
    logic [CNT_W-1:0] stall_cnt;

    ent_t        sb[$];
    int unsigned m_cnt  = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    pipe_stage_latch #(
        .IR_W      (IR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_IR       (in_IR),
        .in_PC_next  (in_PC_next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_IR      (out_IR),
        .out_PC_next (out_PC_next),
        .stall_cnt   (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the latch is a FIFO of depth 2; accepted entries are pushed,
    // consumed entries popped, flush empties it, reset clears everything.
    always @(posedge clock) begin
        bit ev;
        bit er;
        ev = (sb.size() > 0);
        er = (sb.size() < 2);
        if (!reset) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            if (ev && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                sb.delete();
            end else begin
                if (ev && out_ready) void'(sb.pop_front());
                if (in_valid && er) sb.push_back('{ir: in_IR, pc: in_PC_next});
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
            check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
            if (sb.size() > 0) begin
                check("out_IR", 64'(out_IR), 64'(sb[0].ir));
                check("out_PC_next", 64'(out_PC_next), 64'(sb[0].pc));
            end else begin
                check("out_IR_bubble", 64'(out_IR), 64'(NOP));
                check("out_PC_bubble", 64'(out_PC_next), 64'd0);
            end
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [IR_W-1:0] ir, input logic [PC_W-1:0] pc);
        in_valid   = 1'b1;
        in_IR      = ir;
        in_PC_next = pc;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_IR"}, 64'(out_IR), 64'(NOP));
        check({tag, "_out_PC"}, 64'(out_PC_next), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        // 1: reset held low for three cycles
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        step();
        reset = 1'b1;
        check_reset_vals("reset");
        step();
        check_reset_vals("post_reset");

        // 2: streaming with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            in_IR      = IR_W'(32'hA0 + i);
            in_PC_next = PC_W'(i + 1);
            step();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_out_IR", 64'(out_IR), 64'(32'hA0 + i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 64'(out_valid), 64'd0);

        // 3: fill the skid while stalled, then drain in order
        out_ready = 1'b0;
        send(32'h11, 32'd1);
        send(32'h22, 32'd2);
        check("two_in_ready", 64'(in_ready), 64'd0);
        check("two_head_held", 64'(out_IR), 64'h11);
        step();
        check("two_hold_IR", 64'(out_IR), 64'h11);
        out_ready = 1'b1;
        step();
        check("drain_second", 64'(out_IR), 64'h22);
        check("drain_in_ready", 64'(in_ready), 64'd1);
        step();
        check("drain_empty", 64'(out_valid), 64'd0);

        // 4: flush in TWO with a concurrent incoming entry
        out_ready = 1'b0;
        send(32'h44, 32'd4);
        send(32'h55, 32'd5);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_IR      = 32'h33;
        in_PC_next = 32'd3;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_IR", 64'(out_IR), 64'(NOP));
        check("flush_PC", 64'(out_PC_next), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Random traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_IR      = IR_W'($urandom);
            in_PC_next = PC_W'($urandom);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 40) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        // 5: long stall saturates the counter
        out_ready = 1'b0;
        repeat (3) step();
        send(32'h66, 32'd6);
        repeat (70000) step();
        check("stall_saturated", 64'(stall_cnt), 64'(CNT_MAX));
        repeat (10) step();
        check("stall_stays", 64'(stall_cnt), 64'(CNT_MAX));

        // 6: reset in TWO overrides flush and an incoming entry
        send(32'h77, 32'd7);
        check("pre_reset_two", 64'(in_ready), 64'd0);
        reset      = 1'b0;
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_IR      = 32'h88;
        in_PC_next = 32'd8;
        step();
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("reset_in_two");
        step();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
